// File: rtl/sseg_scan_decoder.sv
//------------------------------------------------------------------------------
// sseg_scan_decoder
//
// Watches a time-multiplexed, active-low seven-segment display bus and recovers
// the hex value shown on each digit. Every {an, sseg} sample is registered. A
// sample is accepted only after it has been seen unchanged for STABLE_CYCLES
// consecutive samples, which filters scan transitions and ghosting. Accepted
// samples update the per-digit nibble, flag non-hex segment patterns or illegal
// anode combinations, and a pulse marks each completed display frame.
//
// Parameters:
//   NUM_DIGITS     number of multiplexed digits / anode lines
//   STABLE_CYCLES  identical consecutive samples needed for acceptance (2..255)
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous, active-low reset
//   an           anode selects, active-low (bit i low selects digit i)
//   sseg         segment lines, active-low, gfedcba (bit6 = g, bit0 = a)
//   hex_out      decoded digits, nibble i = hex_out[4i+3:4i]
//   digit_valid  bit i set while nibble i holds a decoded value
//   frame_done   one-cycle pulse once every digit has been accepted
//   bad_pattern  one-cycle pulse: accepted one-hot anode, non-hex segments
//   err_an       one-cycle pulse: accepted sample with several anodes low
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module sseg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              sseg,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    bad_pattern,
    output logic                    err_an
);

    localparam int              SW      = NUM_DIGITS + 7;
    localparam int              CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           sample_q;
    logic [SW-1:0]           sample_in;
    logic [CW-1:0]           count_q, count_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_set;
    logic [4*NUM_DIGITS-1:0] hex_d;
    logic [NUM_DIGITS-1:0]   valid_d;
    logic                    frame_d, bad_d, err_d;
    logic                    changed, accept;
    logic [NUM_DIGITS-1:0]   an_low;
    logic                    an_none, an_onehot;
    logic                    pat_ok;
    logic [3:0]              pat_val;

    assign sample_in = {an, sseg};
    assign changed   = (sample_in != sample_q);
    assign an_low    = ~an;
    assign an_none   = (an_low == '0);
    assign an_onehot = $onehot(an_low);

    // Segment pattern to hex value lookup. Anything outside the sixteen
    // legal glyphs, including a blank display, is reported as invalid.
    always_comb begin
        pat_ok  = 1'b1;
        pat_val = 4'h0;
        case (sseg)
            7'h40: pat_val = 4'h0;
            7'h79: pat_val = 4'h1;
            7'h24: pat_val = 4'h2;
            7'h30: pat_val = 4'h3;
            7'h19: pat_val = 4'h4;
            7'h12: pat_val = 4'h5;
            7'h02: pat_val = 4'h6;
            7'h78: pat_val = 4'h7;
            7'h00: pat_val = 4'h8;
            7'h10: pat_val = 4'h9;
            7'h08: pat_val = 4'hA;
            7'h03: pat_val = 4'hB;
            7'h46: pat_val = 4'hC;
            7'h21: pat_val = 4'hD;
            7'h06: pat_val = 4'hE;
            7'h0E: pat_val = 4'hF;
            default: pat_ok = 1'b0;
        endcase
    end

    // Stability counter: restarts at one on any change of the sampled bus and
    // otherwise counts up, saturating so a long hold cannot wrap around.
    always_comb begin
        count_d = count_q;
        if (changed) begin
            count_d = CNT_ONE;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_ONE;
        end
    end

    // Next-state logic. A blank anode bus always parks the FSM in IDLE. The
    // acceptance point is the edge on which the counter reaches its limit
    // while settling, so a held value is accepted once and then held.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        if (an_none) begin
            state_d = IDLE;
        end else if (changed) begin
            state_d = SETTLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SETTLE;
                SETTLE: begin
                    if (count_d == CNT_MAX) begin
                        state_d = HOLD;
                        accept  = 1'b1;
                    end
                end
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output update on acceptance. The seen mask includes the digit being
    // accepted this cycle, so the frame pulse and the mask clear coincide
    // with the final digit of the frame.
    always_comb begin
        hex_d    = hex_out;
        valid_d  = digit_valid;
        seen_set = seen_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        bad_d    = 1'b0;
        err_d    = 1'b0;
        if (accept) begin
            if (an_onehot) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_low[i]) begin
                        seen_set[i] = 1'b1;
                        if (pat_ok) begin
                            hex_d[4*i +: 4] = pat_val;
                            valid_d[i]      = 1'b1;
                        end else begin
                            valid_d[i] = 1'b0;
                            bad_d      = 1'b1;
                        end
                    end
                end
                if (&seen_set) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d = seen_set;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State and output registers. The sample register resets to all ones so
    // an idle, blank bus right after reset is not seen as a change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sample_q    <= '1;
            count_q     <= '0;
            seen_q      <= '0;
            hex_out     <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            err_an      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_in;
            count_q     <= count_d;
            seen_q      <= seen_d;
            hex_out     <= hex_d;
            digit_valid <= valid_d;
            frame_done  <= frame_d;
            bad_pattern <= bad_d;
            err_an      <= err_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
//------------------------------------------------------------------------------
// tb_sseg_scan_decoder
//
// Drives scan sequences from a table of {anode, segments, hold length,
// expected digits, expected valid mask, expected pulse} records. Each record
// with a pulse schedules {cycle, kind} on a queue; a monitor on the falling
// edge pops and compares every pulse it sees and flags pulses that never came.
// Digit and valid outputs are compared at the end of every record. Reset at
// start-up and in mid-count is exercised by hand-written sequences.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sseg_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;
    localparam int NPRE   = 23;
    localparam int NVEC   = 27;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  sseg;
        int          hold;
        logic [15:0] hex;
        logic [3:0]  valid;
        logic [2:0]  pulse;
    } vec_t;

    typedef struct {
        int         cycle;
        logic [2:0] kind;
    } exp_t;

    logic               clk;
    logic               reset_n;
    logic [NDIG-1:0]    an;
    logic [6:0]         sseg;
    logic [4*NDIG-1:0]  hex_out;
    logic [NDIG-1:0]    digit_valid;
    logic               frame_done;
    logic               bad_pattern;
    logic               err_an;

    vec_t vecs [NVEC];
    exp_t pq[$];
    exp_t mon_e;
    logic [2:0] mon_p;
    int   ecount;
    int   checks;
    int   errors;

    sseg_scan_decoder #(
        .NUM_DIGITS    (NDIG),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .an          (an),
        .sseg        (sseg),
        .hex_out     (hex_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern),
        .err_an      (err_an)
    );

    // Free-running clock and edge counter used to timestamp pulses.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial ecount = 0;
    always @(posedge clk) ecount++;

    // Pulse monitor: every pulse must match the oldest scheduled entry in
    // both kind and cycle; entries whose cycle has passed were missed.
    always @(negedge clk) begin
        while (pq.size() > 0 && pq[0].cycle < ecount) begin
            mon_e = pq.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL pulse missed: got none, expected kind %b at cycle %0d",
                     mon_e.kind, mon_e.cycle);
        end
        mon_p = {err_an, bad_pattern, frame_done};
        if (mon_p != 3'b000) begin
            checks++;
            if (pq.size() == 0) begin
                errors++;
                $display("[TB] FAIL pulse unexpected: got kind %b at cycle %0d, expected none",
                         mon_p, ecount);
            end else begin
                mon_e = pq.pop_front();
                if (mon_p !== mon_e.kind || ecount != mon_e.cycle) begin
                    errors++;
                    $display("[TB] FAIL pulse: got kind %b at cycle %0d, expected kind %b at cycle %0d",
                             mon_p, ecount, mon_e.kind, mon_e.cycle);
                end
            end
        end
    end

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one record from a falling edge, schedule its pulse, and hold it.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        an   = v.an;
        sseg = v.sseg;
        if (v.pulse != 3'b000) begin
            e.cycle = ecount + STABLE;
            e.kind  = v.pulse;
            pq.push_back(e);
        end
        repeat (v.hold) @(negedge clk);
    endtask

    // Pulse kind bits are {err_an, bad_pattern, frame_done}.
    initial begin
        checks  = 0;
        errors  = 0;

        // full frame 3,2,1,0
        vecs[0]  = '{4'b1110, 7'h30,  8, 16'h0003, 4'h1, 3'b000};
        vecs[1]  = '{4'b1101, 7'h24,  8, 16'h0023, 4'h3, 3'b000};
        vecs[2]  = '{4'b1011, 7'h79,  8, 16'h0123, 4'h7, 3'b000};
        vecs[3]  = '{4'b0111, 7'h40,  8, 16'h0123, 4'hF, 3'b001};
        // short F glitch, then E
        vecs[4]  = '{4'b1110, 7'h0E,  2, 16'h0123, 4'hF, 3'b000};
        vecs[5]  = '{4'b1110, 7'h06, 10, 16'h012E, 4'hF, 3'b000};
        // blank on digit 1, then two anodes low
        vecs[6]  = '{4'b1101, 7'h7F,  6, 16'h012E, 4'hD, 3'b010};
        vecs[7]  = '{4'b1100, 7'h00,  6, 16'h012E, 4'hD, 3'b100};
        // full scan 4,5,6,7 gives a single frame pulse
        vecs[8]  = '{4'b1110, 7'h19,  5, 16'h0124, 4'hD, 3'b000};
        vecs[9]  = '{4'b1101, 7'h12,  5, 16'h0154, 4'hF, 3'b000};
        vecs[10] = '{4'b1011, 7'h02,  5, 16'h0654, 4'hF, 3'b000};
        vecs[11] = '{4'b0111, 7'h78,  5, 16'h7654, 4'hF, 3'b001};
        // long hold
        vecs[12] = '{4'b0111, 7'h10, 50, 16'h9654, 4'hF, 3'b000};
        // frame completed by a bad pattern: both pulses together
        vecs[13] = '{4'b1110, 7'h08,  6, 16'h965A, 4'hF, 3'b000};
        vecs[14] = '{4'b1101, 7'h03,  6, 16'h96BA, 4'hF, 3'b000};
        vecs[15] = '{4'b1011, 7'h7F,  6, 16'h96BA, 4'hB, 3'b011};
        // hold exactly STABLE, then STABLE-1
        vecs[16] = '{4'b1011, 7'h46,  4, 16'h9CBA, 4'hF, 3'b000};
        vecs[17] = '{4'b0111, 7'h21,  3, 16'h9CBA, 4'hF, 3'b000};
        vecs[18] = '{4'b0111, 7'h00,  4, 16'h8CBA, 4'hF, 3'b000};
        vecs[19] = '{4'b1110, 7'h0E,  4, 16'h8CBF, 4'hF, 3'b000};
        vecs[20] = '{4'b1101, 7'h21,  4, 16'h8CDF, 4'hF, 3'b001};
        // one-sample glitch returning to the held value
        vecs[21] = '{4'b1101, 7'h22,  1, 16'h8CDF, 4'hF, 3'b000};
        vecs[22] = '{4'b1101, 7'h21,  5, 16'h8CDF, 4'hF, 3'b000};
        // after mid-run reset: seen mask must restart from empty
        vecs[23] = '{4'b1110, 7'h40,  6, 16'h0000, 4'h1, 3'b000};
        vecs[24] = '{4'b1011, 7'h79,  6, 16'h0100, 4'h5, 3'b000};
        vecs[25] = '{4'b0111, 7'h79,  6, 16'h1100, 4'hD, 3'b000};
        vecs[26] = '{4'b1101, 7'h30,  6, 16'h1130, 4'hF, 3'b001};

        // Power-on reset with an idle bus.
        reset_n = 1'b0;
        an      = 4'b1111;
        sseg    = 7'h7F;
        repeat (2) @(negedge clk);
        checkOutput("reset hex_out", 32'(hex_out), 32'h0);
        checkOutput("reset digit_valid", 32'(digit_valid), 32'h0);
        checkOutput("reset frame_done", 32'(frame_done), 32'h0);
        checkOutput("reset bad_pattern", 32'(bad_pattern), 32'h0);
        checkOutput("reset err_an", 32'(err_an), 32'h0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("idle hex_out", 32'(hex_out), 32'h0);
        checkOutput("idle digit_valid", 32'(digit_valid), 32'h0);

        for (int i = 0; i < NPRE; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d hex_out", i), 32'(hex_out), 32'(vecs[i].hex));
            checkOutput($sformatf("row%0d digit_valid", i), 32'(digit_valid), 32'(vecs[i].valid));
        end

        // Reset in the middle of a count on a populated display.
        an   = 4'b1110;
        sseg = 7'h40;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset hex_out", 32'(hex_out), 32'h0);
        checkOutput("midreset digit_valid", 32'(digit_valid), 32'h0);
        checkOutput("midreset pulses", 32'({err_an, bad_pattern, frame_done}), 32'h0);
        @(negedge clk);
        an   = 4'b1111;
        sseg = 7'h7F;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("postreset hex_out", 32'(hex_out), 32'h0);
        checkOutput("postreset digit_valid", 32'(digit_valid), 32'h0);

        for (int i = NPRE; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d hex_out", i), 32'(hex_out), 32'(vecs[i].hex));
            checkOutput($sformatf("row%0d digit_valid", i), 32'(digit_valid), 32'(vecs[i].valid));
        end

        repeat (STABLE + 2) @(negedge clk);
        while (pq.size() > 0) begin
            mon_e = pq.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL pulse never seen: got none, expected kind %b at cycle %0d",
                     mon_e.kind, mon_e.cycle);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Monitors a time-multiplexed, active-low seven-segment display bus (anode selects plus gfedcba segments) and recovers the hex value shown on each digit.
- Filters scan transitions and ghosting with a stability counter, flags non-hex patterns and illegal anode combinations, and pulses once per completed display frame.
- Used as an on-chip display self-check and loopback monitor for the display driver.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits and anode lines
STABLE_CYCLES, 4, consecutive identical samples required before a sample is accepted (legal range 2..255)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
an  input  NUM_DIGITS  anode selects, active-low; bit i low selects digit i
sseg  input  7  segment lines, active-low, bit order gfedcba (bit6=g, bit0=a)
hex_out  output  4*NUM_DIGITS  decoded digits; nibble i = hex_out[4i+3:4i]
digit_valid  output  NUM_DIGITS  bit i set when nibble i holds a decoded value
frame_done  output  1  one-cycle pulse when every digit has been accepted since the last pulse
bad_pattern  output  1  one-cycle pulse when an accepted sample has a one-hot anode but a non-hex segment pattern
err_an  output  1  one-cycle pulse when an accepted sample has more than one anode low

Behaviour:
- Reset (asynchronous, reset_n low) clears all state:
  - hex_out = 0, digit_valid = 0, frame_done = 0, bad_pattern = 0, err_an = 0.
  - Sample register = all ones (blank), stability count = 0, seen mask = 0, FSM = IDLE.
- Sampling:
  - {an, sseg} is registered every edge.
  - If the new value differs from the previous sample, the count loads 1 and the FSM enters SETTLE.
  - If the value is equal, the count increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: an is all ones. Nothing is captured, and all-ones an is never flagged as an error.
  - SETTLE: counting toward STABLE_CYCLES.
  - HOLD: sample accepted; waits here for the next change, with no re-acceptance while the value is held.
- Acceptance: when the count reaches STABLE_CYCLES in SETTLE, the sample is accepted and the FSM moves to HOLD. Outputs update on the same edge. For inputs first sampled at edge k and held, outputs change at edge k+STABLE_CYCLES-1.
- Accepted sample, one-hot an (digit i):
  - Valid pattern: nibble i = decoded value, digit_valid[i] = 1, seen[i] = 1.
  - Invalid pattern: nibble i unchanged, digit_valid[i] = 0, bad_pattern pulses, seen[i] = 1. Blank 7'h7F counts as invalid.
- Accepted sample with two or more anodes low: err_an pulses; no nibble, valid or seen bit changes.
- Decode table (sseg hex -> value):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
  - Any other pattern is invalid.
- Frame completion:
  - When the seen mask (including the bit set this cycle) becomes all ones, frame_done pulses and the seen mask clears on the same edge.
  - Revisiting an already-seen digit within a frame updates the nibble but does not pulse.
- Glitch rejection: any change shorter than STABLE_CYCLES samples restarts the count. A glitch that returns to the held value re-enters SETTLE and re-accepts the same value, which is harmless and idempotent.
- Pulse timing: all pulses are registered and exactly one cycle wide. bad_pattern and frame_done may assert in the same cycle.
- Reset mid-operation: asynchronous clear of everything, including a partially counted sample and a partially seen frame.
- Pure decode: no arithmetic beyond the saturating counter, whose width is clog2(STABLE_CYCLES+1).

Test Plan:
- Reset check: reset_n low mid-count -> all outputs 0 immediately. Release with an=4'b1111 held -> no pulses; FSM stays IDLE.
- Full frame: scan digits 0..3 with sseg 30, 24, 79, 40, each held 8 cycles -> hex_out=16'h0123, digit_valid=4'hF, one frame_done pulse on the 4th acceptance, exactly STABLE_CYCLES-1 edges after that digit's first sample.
- Glitch rejection: an=4'b1110, sseg=0E held 2 cycles, then sseg=06 held 10 cycles -> nibble0=E (never F), no bad_pattern.
- Invalid pattern: an=4'b1101, sseg=7'h7F held 6 cycles -> one bad_pattern pulse; digit_valid[1]=0; nibble1 unchanged.
- Illegal anodes: an=4'b1100, sseg=00 held 6 cycles -> one err_an pulse; hex_out, digit_valid and seen unchanged; the next legal full scan still yields a single frame_done.
- Hold behaviour: an=4'b0111, sseg=10 held 50 cycles -> exactly one acceptance (nibble3=9); no repeated pulses.
